// File: rtl/peripheral_wb_master_bb.sv
// rtl/peripheral_wb_master_bb.sv - Wishbone B3 burst master driven by a single command interface
//
// Purpose: turns one command (start address, beat count, direction, wrap mode)
// into a Wishbone classic cycle or an incrementing/wrapping burst. Write data
// arrives on a valid/ready stream, read data leaves as one-cycle pulses, and a
// done/err pulse closes every command.
//
// Ports:
//   wb_clk_i, wb_rst_i            clock, synchronous active-high reset
//   cmd_valid_i / cmd_ready_o     command handshake (ready only in IDLE)
//   cmd_adr_i, cmd_we_i,
//   cmd_len_i, cmd_bte_i          command fields (len 0 -> 1, len > MAX_BURST clamped)
//   wdat_valid_i / wdat_ready_o,
//   wdat_i                        write-data stream, one word per beat
//   rdat_valid_o, rdat_o          read-data pulse per acked read beat
//   done_o, err_o                 end-of-command pulse and its error status
//   wb_*_o / wb_*_i               Wishbone master outputs and slave responses
`timescale 1ns/1ps

module peripheral_wb_master_bb #(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int MAX_BURST = 16,
  parameter int RTY_LIMIT = 4,
  localparam int LW = $clog2(MAX_BURST) + 1
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic [AW-1:0]   cmd_adr_i,
  input  logic            cmd_we_i,
  input  logic [LW-1:0]   cmd_len_i,
  input  logic [1:0]      cmd_bte_i,
  input  logic            wdat_valid_i,
  output logic            wdat_ready_o,
  input  logic [DW-1:0]   wdat_i,
  output logic            rdat_valid_o,
  output logic [DW-1:0]   rdat_o,
  output logic            done_o,
  output logic            err_o,
  output logic [AW-1:0]   wb_adr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic            wb_we_o,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic [2:0]      wb_cti_o,
  output logic [1:0]      wb_bte_o,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic            wb_ack_i,
  input  logic            wb_err_i,
  input  logic            wb_rty_i
);

  localparam int BW = DW / 8;
  localparam int RW = $clog2(RTY_LIMIT + 2);

  typedef enum logic [2:0] {IDLE, WDATA, BUS, GAP, FIN} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   adr_q, adr_d;
  logic [DW-1:0]   dat_q, dat_d;
  logic            we_q, we_d;
  logic [1:0]      bte_q, bte_d;
  logic            multi_q, multi_d;
  logic [LW-1:0]   rem_q, rem_d;
  logic [RW-1:0]   rty_q, rty_d;
  logic            err_q, err_d;
  logic            cyc_q, cyc_d, stb_q, stb_d, weo_q, weo_d;
  logic [2:0]      cti_q, cti_d;
  logic [1:0]      bteo_q, bteo_d;
  logic            rdv_q, rdv_d, done_q, done_d, erro_q, erro_d;
  logic [DW-1:0]   rdat_q, rdat_d;
  logic [LW-1:0]   len_eff;
  logic [AW-1:0]   wrap_mask, adr_inc, adr_next;

  // Wrapping bursts only advance the low log2(W*B) address bits.
  always_comb begin
    wrap_mask = '0;
    case (bte_q)
      2'b01:   wrap_mask = AW'(4 * BW - 1);
      2'b10:   wrap_mask = AW'(8 * BW - 1);
      2'b11:   wrap_mask = AW'(16 * BW - 1);
      default: wrap_mask = '0;
    endcase
    adr_inc  = adr_q + AW'(BW);
    adr_next = (bte_q == 2'b00) ? adr_inc : ((adr_q & ~wrap_mask) | (adr_inc & wrap_mask));
  end

  always_comb begin
    len_eff = cmd_len_i;
    if (cmd_len_i == '0) begin
      len_eff = LW'(1);
    end else if (cmd_len_i > LW'(MAX_BURST)) begin
      len_eff = LW'(MAX_BURST);
    end
  end

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    we_d    = we_q;
    bte_d   = bte_q;
    multi_d = multi_q;
    rem_d   = rem_q;
    rty_d   = rty_q;
    err_d   = err_q;
    rdv_d   = 1'b0;
    rdat_d  = rdat_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          adr_d   = cmd_adr_i;
          we_d    = cmd_we_i;
          bte_d   = cmd_bte_i;
          rem_d   = len_eff;
          multi_d = (len_eff > LW'(1));
          rty_d   = '0;
          err_d   = 1'b0;
          state_d = cmd_we_i ? WDATA : BUS;
        end
      end
      WDATA: begin
        if (wdat_valid_i) begin
          dat_d   = wdat_i;
          state_d = BUS;
        end
      end
      BUS: begin
        // A retry that would push the count past the limit ends the command as an error.
        if (wb_err_i || (wb_rty_i && rty_q >= RW'(RTY_LIMIT))) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else if (wb_rty_i) begin
          rty_d   = rty_q + RW'(1);
          state_d = GAP;
        end else if (wb_ack_i) begin
          rem_d = rem_q - LW'(1);
          adr_d = adr_next;
          if (!we_q) begin
            rdv_d  = 1'b1;
            rdat_d = wb_dat_i;
          end
          if (rem_q == LW'(1)) begin
            state_d = FIN;
          end else begin
            state_d = we_q ? WDATA : BUS;
          end
        end
      end
      GAP:     state_d = BUS;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Bus outputs are derived from the next state so they register alongside it.
    cyc_d  = (state_d == WDATA) || (state_d == BUS);
    stb_d  = (state_d == BUS);
    weo_d  = cyc_d && we_d;
    cti_d  = 3'b000;
    bteo_d = 2'b00;
    if (cyc_d) begin
      cti_d  = (rem_d == LW'(1)) ? (multi_d ? 3'b111 : 3'b000) : 3'b010;
      bteo_d = multi_d ? bte_d : 2'b00;
    end
    done_d = (state_d == FIN);
    erro_d = (state_d == FIN) && err_d;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      bte_q   <= 2'b00;
      multi_q <= 1'b0;
      rem_q   <= '0;
      rty_q   <= '0;
      err_q   <= 1'b0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      weo_q   <= 1'b0;
      cti_q   <= 3'b000;
      bteo_q  <= 2'b00;
      rdv_q   <= 1'b0;
      rdat_q  <= '0;
      done_q  <= 1'b0;
      erro_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      we_q    <= we_d;
      bte_q   <= bte_d;
      multi_q <= multi_d;
      rem_q   <= rem_d;
      rty_q   <= rty_d;
      err_q   <= err_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      weo_q   <= weo_d;
      cti_q   <= cti_d;
      bteo_q  <= bteo_d;
      rdv_q   <= rdv_d;
      rdat_q  <= rdat_d;
      done_q  <= done_d;
      erro_q  <= erro_d;
    end
  end

  assign cmd_ready_o  = (state_q == IDLE);
  assign wdat_ready_o = (state_q == WDATA);
  assign rdat_valid_o = rdv_q;
  assign rdat_o       = rdat_q;
  assign done_o       = done_q;
  assign err_o        = erro_q;
  assign wb_adr_o     = adr_q;
  assign wb_dat_o     = dat_q;
  assign wb_sel_o     = '1;
  assign wb_we_o      = weo_q;
  assign wb_cyc_o     = cyc_q;
  assign wb_stb_o     = stb_q;
  assign wb_cti_o     = cti_q;
  assign wb_bte_o     = bteo_q;

endmodule

// File: tb/tb_peripheral_wb_master_bb.sv
// tb/tb_peripheral_wb_master_bb.sv - scoreboard bench for the Wishbone burst master
`timescale 1ns/1ps

module tb_peripheral_wb_master_bb;
  localparam int DW = 32, AW = 32, MAXB = 16, RLIM = 4, LW = 5;

  logic wb_clk_i = 1'b0;
  logic wb_rst_i = 1'b1;
  logic cmd_valid_i = 1'b0, cmd_ready_o, cmd_we_i = 1'b0;
  logic [AW-1:0] cmd_adr_i = '0;
  logic [LW-1:0] cmd_len_i = '0;
  logic [1:0] cmd_bte_i = '0;
  logic wdat_valid_i = 1'b0, wdat_ready_o;
  logic [DW-1:0] wdat_i = '0;
  logic rdat_valid_o, done_o, err_o;
  logic [DW-1:0] rdat_o, wb_dat_o;
  logic [AW-1:0] wb_adr_o;
  logic [3:0] wb_sel_o;
  logic wb_we_o, wb_cyc_o, wb_stb_o;
  logic [2:0] wb_cti_o;
  logic [1:0] wb_bte_o;
  logic [DW-1:0] wb_dat_i = '0;
  logic wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0;

  always #5 wb_clk_i = ~wb_clk_i;

  peripheral_wb_master_bb #(.DW(DW), .AW(AW), .MAX_BURST(MAXB), .RTY_LIMIT(RLIM)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_adr_i(cmd_adr_i),
    .cmd_we_i(cmd_we_i), .cmd_len_i(cmd_len_i), .cmd_bte_i(cmd_bte_i),
    .wdat_valid_i(wdat_valid_i), .wdat_ready_o(wdat_ready_o), .wdat_i(wdat_i),
    .rdat_valid_o(rdat_valid_o), .rdat_o(rdat_o), .done_o(done_o), .err_o(err_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
  );

  // kind: 0 = acked beat, 1 = beat that ends the command, 2 = retried beat that is reissued
  typedef struct {
    logic [31:0] adr;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        we;
    logic [31:0] dat;
    int          kind;
  } beat_t;

  beat_t       exp_bus[$];
  logic [31:0] exp_rd[$];
  logic        exp_done[$];
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic [31:0] wd [16];

  int n_tests = 0, n_fail = 0;
  int s_err_at = -1, s_rty_at = -1, s_rty_n = 0, s_beat = 0, s_rty_given = 0, s_wait = 0, s_wmax = 2;
  bit chk_low = 0, chk_reissue = 0, chk_re2 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] beat_addr(input logic [31:0] start, input int i, input logic [1:0] bte);
    logic [31:0] span;
    span = (bte == 2'd1) ? 32'd16 : (bte == 2'd2) ? 32'd32 : (bte == 2'd3) ? 32'd64 : 32'd0;
    if (span == 0) return start + 32'(i * 4);
    return (start - (start % span)) + ((start + 32'(i * 4)) % span);
  endfunction

  // Slave BFM: responds after a random wait; err/rty injection by beat index.
  initial begin
    forever begin
      @(posedge wb_clk_i);
      #1;
      wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0; wb_dat_i = $urandom;
      if (wb_cyc_o && wb_stb_o) begin
        if (s_wait > 0) s_wait--;
        else begin
          if (s_beat == s_rty_at && s_rty_given < s_rty_n) begin
            wb_rty_i = 1; s_rty_given++;
          end else if (s_beat == s_err_at) begin
            wb_err_i = 1;
          end else begin
            wb_ack_i = 1; s_beat++;
            if (wb_we_o) mem[wb_adr_o[9:2]] = wb_dat_o;
            else wb_dat_i = mem[wb_adr_o[9:2]];
          end
          s_wait = $urandom_range(0, s_wmax);
        end
      end
    end
  end

  // Bus monitor
  initial begin
    beat_t e;
    forever begin
      @(negedge wb_clk_i);
      if (chk_low) begin
        check("cyc_drop", {31'd0, wb_cyc_o}, 32'd0);
        chk_low = 0; chk_re2 = chk_reissue; chk_reissue = 0;
      end else if (chk_re2) begin
        check("reissue_after_gap", {30'd0, wb_cyc_o, wb_stb_o}, 32'd3);
        chk_re2 = 0;
      end
      if (wb_cyc_o && wb_stb_o && (wb_ack_i || wb_err_i || wb_rty_i)) begin
        if (exp_bus.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL extra_beat: got beat at 0x%0h expected none", wb_adr_o);
        end else begin
          e = exp_bus.pop_front();
          check("beat_adr", wb_adr_o, e.adr);
          check("beat_cti", {29'd0, wb_cti_o}, {29'd0, e.cti});
          check("beat_bte", {30'd0, wb_bte_o}, {30'd0, e.bte});
          check("beat_we", {31'd0, wb_we_o}, {31'd0, e.we});
          check("beat_sel", {28'd0, wb_sel_o}, 32'hf);
          if (e.we) check("beat_wdat", wb_dat_o, e.dat);
          if (e.kind != 0) begin chk_low = 1; chk_reissue = (e.kind == 2); end
        end
      end
    end
  end

  // Read-data monitor
  initial begin
    logic [31:0] d;
    forever begin
      @(negedge wb_clk_i);
      if (rdat_valid_o === 1'b1) begin
        if (exp_rd.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL extra_rdat: got 0x%0h expected no pulse", rdat_o);
        end else begin
          d = exp_rd.pop_front();
          check("rdat", rdat_o, d);
        end
      end
    end
  end

  // Completion monitor
  initial begin
    logic x;
    forever begin
      @(negedge wb_clk_i);
      if (done_o === 1'b1) begin
        if (exp_done.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL extra_done: got done err=%0d expected no pulse", err_o);
        end else begin
          x = exp_done.pop_front();
          check("done_err", {31'd0, err_o}, {31'd0, x});
        end
      end
    end
  end

  task automatic flush();
    exp_bus.delete(); exp_rd.delete(); exp_done.delete();
    chk_low = 0; chk_reissue = 0; chk_re2 = 0;
  endtask

  // Builds the expected response from the command rules, arms the slave, hands the command over.
  task automatic issue_cmd(input logic [31:0] adr, input int len, input bit we, input logic [1:0] bte,
                           input int e_at, input int r_at, input int r_n, output int n);
    beat_t b;
    int retries;
    bit ended;
    bit multi;
    n = (len == 0) ? 1 : (len > MAXB ? MAXB : len);
    multi = (n > 1);
    retries = 0; ended = 0;
    for (int i = 0; i < n && !ended; i++) begin
      b.adr = beat_addr(adr, i, multi ? bte : 2'b00);
      b.cti = (n - i == 1) ? (multi ? 3'b111 : 3'b000) : 3'b010;
      b.bte = multi ? bte : 2'b00;
      b.we  = we;
      b.dat = wd[i];
      if (i == r_at) begin
        for (int k = 0; k < r_n && !ended; k++) begin
          retries++;
          b.kind = (retries > RLIM) ? 1 : 2;
          exp_bus.push_back(b);
          if (retries > RLIM) ended = 1;
        end
      end
      if (!ended) begin
        if (i == e_at) begin
          b.kind = 1; exp_bus.push_back(b); ended = 1;
        end else begin
          b.kind = 0; exp_bus.push_back(b);
          if (we) ref_mem[b.adr[9:2]] = wd[i];
          else exp_rd.push_back(ref_mem[b.adr[9:2]]);
        end
      end
    end
    exp_done.push_back(ended);
    s_err_at = e_at; s_rty_at = r_at; s_rty_n = r_n; s_beat = 0; s_rty_given = 0;
    s_wait = $urandom_range(0, s_wmax);
    @(negedge wb_clk_i);
    cmd_adr_i = adr; cmd_len_i = LW'(len); cmd_we_i = we; cmd_bte_i = bte; cmd_valid_i = 1;
    for (int t = 0; t < 50 && !cmd_ready_o; t++) @(negedge wb_clk_i);
    check("cmd_ready_idle", {31'd0, cmd_ready_o}, 32'd1);
    @(negedge wb_clk_i);
    cmd_valid_i = 0;
  endtask

  task automatic do_reset();
    wb_rst_i = 1;
    @(negedge wb_clk_i);
    wb_rst_i = 0;
    flush();
  endtask

  task automatic finish_cmd(input bit we, input int n, input int stall_beat, input int stall_n);
    int k, stall, budget;
    k = 0; budget = 0;
    stall = (stall_beat == 0) ? stall_n : $urandom_range(0, 1);
    while (we && k < n && budget < 1000) begin
      if (done_o || cmd_ready_o) break;
      if (wdat_ready_o) begin
        if (stall > 0) begin
          if (k > 0) check("stall_cyc_stb", {30'd0, wb_cyc_o, wb_stb_o}, 32'd2);
          stall--;
        end else begin
          wdat_valid_i = 1; wdat_i = wd[k];
        end
      end
      @(negedge wb_clk_i);
      budget++;
      if (wdat_valid_i) begin
        wdat_valid_i = 0; wdat_i = $urandom; k++;
        stall = (k == stall_beat) ? stall_n : $urandom_range(0, 1);
      end
    end
    while (!cmd_ready_o && budget < 1000) begin
      @(negedge wb_clk_i);
      budget++;
    end
    if (budget >= 1000) begin
      n_tests++; n_fail++;
      $display("FAIL cmd_timeout: got no completion expected done within 1000 cycles");
      do_reset();
    end
    check("bus_q_empty", exp_bus.size(), 0);
    check("rd_q_empty", exp_rd.size(), 0);
    check("done_q_empty", exp_done.size(), 0);
  endtask

  task automatic run_cmd(input logic [31:0] adr, input int len, input bit we, input logic [1:0] bte,
                         input int e_at, input int r_at, input int r_n, input int stall_beat, input int stall_n);
    int n;
    issue_cmd(adr, len, we, bte, e_at, r_at, r_n, n);
    finish_cmd(we, n, stall_beat, stall_n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected finish before 500us");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom; ref_mem[i] = mem[i];
    end
    repeat (3) @(negedge wb_clk_i);
    wb_rst_i = 0;
    check("rst_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
    check("rst_cyc_stb_we", {29'd0, wb_cyc_o, wb_stb_o, wb_we_o}, 32'd0);
    check("rst_done_err_rdv", {29'd0, done_o, err_o, rdat_valid_o}, 32'd0);
    check("rst_adr", wb_adr_o, 32'd0);
    check("rst_dat", wb_dat_o, 32'd0);
    check("rst_cti_bte", {27'd0, wb_cti_o, wb_bte_o}, 32'd0);

    // classic read
    mem[8'h40] = 32'hDEADBEEF; ref_mem[8'h40] = 32'hDEADBEEF;
    run_cmd(32'h100, 1, 0, 2'b00, -1, -1, 0, -1, 0);
    // linear write of 1..4
    for (int i = 0; i < 16; i++) wd[i] = 32'(i + 1);
    run_cmd(32'h40, 4, 1, 2'b00, -1, -1, 0, -1, 0);
    for (int i = 0; i < 4; i++) check("mem_after_write", mem[16 + i], 32'(i + 1));
    // wrap4 read, back-to-back acks
    s_wmax = 0;
    run_cmd(32'h38, 4, 0, 2'b01, -1, -1, 0, -1, 0);
    s_wmax = 2;
    // write with a 3-cycle stall before beat 3
    for (int i = 0; i < 16; i++) wd[i] = $urandom;
    run_cmd(32'h200, 8, 1, 2'b00, -1, -1, 0, 2, 3);
    // err on beat 2
    run_cmd(32'h80, 4, 0, 2'b00, 1, -1, 0, -1, 0);
    // retry limit exceeded on beat 1
    run_cmd(32'hC0, 4, 0, 2'b00, -1, 0, 5, -1, 0);
    // reset mid-burst
    s_wmax = 3;
    issue_cmd(32'h300, 16, 0, 2'b00, -1, -1, 0, n);
    repeat (10) @(negedge wb_clk_i);
    do_reset();
    check("rst_mid_cyc_stb", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
    repeat (5) @(negedge wb_clk_i);
    check("rst_mid_idle", {31'd0, cmd_ready_o}, 32'd1);

    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < 16; i++) wd[i] = $urandom;
      s_wmax = $urandom_range(0, 2);
      run_cmd({22'd0, 8'($urandom_range(0, 255)), 2'b00}, $urandom_range(0, 20), 1'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)),
              ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15)) : -1,
              ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15)) : -1,
              $urandom_range(1, 6), -1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
